// File: rtl/muldiv_seq_pkg.sv
// Shared RV32M op encodings, sequencer states and op-class helpers for muldiv_seq.
// Pure definitions: no latency, no flow control.
package muldiv_seq_pkg;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [2:0] {
        MD_IDLE = 3'd0,
        MD_PREP = 3'd1,
        MD_ITER = 3'd2,
        MD_FIX  = 3'd3,
        MD_DONE = 3'd4
    } md_state_e;

    function automatic logic is_div(input logic [2:0] f);
        return f[2];
    endfunction

    function automatic logic is_rem(input logic [2:0] f);
        return f[2] & f[1];
    endfunction

    function automatic logic is_mul_hi(input logic [2:0] f);
        return !f[2] && (f[1:0] != 2'b00);
    endfunction

    function automatic logic is_signed_a(input logic [2:0] f);
        return !(f == MD_MULHU || f == MD_DIVU || f == MD_REMU);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] f);
        return (f == MD_MUL || f == MD_MULH || f == MD_DIV || f == MD_REM);
    endfunction

    // Sign of the final result given the operand sign bits.
    function automatic logic res_neg(input logic [2:0] f, input logic sa, input logic sb);
        logic n;
        case (f)
            MD_MUL, MD_MULH, MD_DIV: n = sa ^ sb;
            MD_MULHSU, MD_REM:       n = sa;
            default:                 n = 1'b0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/response bundle between decode/writeback (master) and the M-extension sequencer (slave).
// Request valid/ready, response valid/ready, plus kill and busy pipeline controls.
interface muldiv_seq_if #(
    parameter int XLEN = 32
);
    logic            kill;
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_data;
    logic            busy;

    modport master (
        output kill, req_valid, req_funct3, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_data, busy
    );

    modport slave (
        input  kill, req_valid, req_funct3, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_data, busy
    );

endinterface

// File: rtl/muldiv_addsub.sv
// W-bit adder/subtractor with explicit carry-in; negate is op_a=0, sub=1, cin=1.
// Purely combinational, no flow control.
module muldiv_addsub #(
    parameter int W = 33
) (
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         sub,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    logic [W:0] full;

    // For subtract, cout=1 means no borrow.
    assign full = {1'b0, op_a} + {1'b0, op_b ^ {W{sub}}} + {{W{1'b0}}, cin};
    assign sum  = full[W-1:0];
    assign cout = full[W];

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M MUL/DIV/REM sequencer: one shared adder, XLEN shift-add or restoring steps.
// Latency XLEN+2 after accept (2 on divide-by-zero); result held in DONE until resp_ready.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    muldiv_seq_if.slave bus
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

    md_state_e         state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d, resp_data_q, resp_data_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              neg_q, neg_d;

    logic [XLEN:0]     add_a, add_b, add_sum;
    logic              add_sub, add_cin, add_cout;
    logic [XLEN-1:0]   acc_hi, acc_lo, abs_a, fix_field;
    logic              accept, div_zero;

    assign acc_hi    = acc_q[2*XLEN-1:XLEN];
    assign acc_lo    = acc_q[XLEN-1:0];
    assign accept    = bus.req_valid && !bus.kill;
    assign div_zero  = is_div(op_q) && (b_q == '0);
    assign abs_a     = (is_signed_a(op_q) && a_q[XLEN-1]) ? add_sum[XLEN-1:0] : a_q;
    assign fix_field = (is_mul_hi(op_q) || is_rem(op_q)) ? acc_hi : acc_lo;

    muldiv_addsub #(.W(XLEN + 1)) u_addsub (
        .op_a (add_a),
        .op_b (add_b),
        .sub  (add_sub),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Adder is idle in IDLE, so it negates rs2 there; PREP reuses it to negate rs1.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_sub = 1'b1;
        add_cin = 1'b1;
        case (state_q)
            MD_IDLE: add_b = {1'b0, bus.req_b};
            MD_PREP: add_b = {1'b0, a_q};
            MD_ITER: begin
                if (is_div(op_q)) begin
                    add_a = acc_q[2*XLEN-1:XLEN-1];
                    add_b = {1'b0, b_q};
                end else begin
                    add_a   = {1'b0, acc_hi};
                    add_b   = {1'b0, a_q};
                    add_sub = 1'b0;
                    add_cin = 1'b0;
                end
            end
            MD_FIX: begin
                if (is_mul_hi(op_q)) begin
                    // High half of a negated product: ~hi plus carry out of the low half.
                    add_a   = {1'b0, ~acc_hi};
                    add_sub = 1'b0;
                    add_cin = (acc_lo == '0);
                end else begin
                    add_b = {1'b0, fix_field};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= MD_IDLE;
        else        state_q <= state_d;
    end

    // Divide-by-zero skips ITER but passes through FIX to load the fixed result.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MD_IDLE: if (bus.req_valid) state_d = MD_PREP;
            MD_PREP: state_d = div_zero ? MD_FIX : MD_ITER;
            MD_ITER: if (cnt_q == LAST) state_d = MD_FIX;
            MD_FIX:  state_d = MD_DONE;
            MD_DONE: if (bus.resp_ready) state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
        if (bus.kill) state_d = MD_IDLE;
    end

    always_comb begin
        bus.req_ready  = rst_n && (state_q == MD_IDLE);
        bus.busy       = (state_q != MD_IDLE);
        bus.resp_valid = (state_q == MD_DONE);
        bus.resp_data  = resp_data_q;
    end

    always_comb begin
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        neg_d       = neg_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        resp_data_d = resp_data_q;
        case (state_q)
            MD_IDLE: if (accept) begin
                op_d  = bus.req_funct3;
                a_d   = bus.req_a;
                b_d   = (is_signed_b(bus.req_funct3) && bus.req_b[XLEN-1]) ?
                        add_sum[XLEN-1:0] : bus.req_b;
                neg_d = res_neg(bus.req_funct3, bus.req_a[XLEN-1], bus.req_b[XLEN-1]);
            end
            MD_PREP: begin
                cnt_d = '0;
                if (is_div(op_q)) begin
                    acc_d = {{XLEN{1'b0}}, abs_a};
                end else begin
                    a_d   = abs_a;
                    acc_d = {{XLEN{1'b0}}, b_q};
                end
            end
            MD_ITER: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (is_div(op_q)) begin
                    acc_d = add_cout ? {add_sum[XLEN-1:0], acc_q[XLEN-2:0], 1'b1}
                                     : {acc_q[2*XLEN-2:0], 1'b0};
                end else begin
                    acc_d = acc_q[0] ? {add_sum, acc_q[XLEN-1:1]}
                                     : {1'b0, acc_q[2*XLEN-1:1]};
                end
            end
            MD_FIX: begin
                if (div_zero) resp_data_d = is_rem(op_q) ? a_q : '1;
                else          resp_data_d = neg_q ? add_sum[XLEN-1:0] : fix_field;
            end
            default: ;
        endcase
        if (bus.kill) begin
            cnt_d       = '0;
            resp_data_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            neg_q       <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            resp_data_q <= '0;
        end else begin
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            neg_q       <= neg_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            resp_data_q <= resp_data_d;
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: vector table plus scoreboard of expected responses and latencies.
// Hand sequences cover kill, backpressure in DONE and reset mid-operation.
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    muldiv_seq_if #(.XLEN(32)) bus ();

    muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string       tag;
        logic [31:0] data;
        int          lat;
        int          acc_cyc;
    } exp_t;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_resp  = 0;
    int   cyc     = 0;
    int   vld_rise = 0;
    logic vld_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Response monitor: samples on the falling edge, pops the scoreboard on each handshake.
    always @(negedge clk) begin : mon
        exp_t e;
        if (bus.resp_valid === 1'b1 && vld_prev !== 1'b1) vld_rise = cyc;
        vld_prev = bus.resp_valid;
        if (bus.resp_valid === 1'b1 && bus.resp_ready === 1'b1) begin
            n_resp++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_resp: got resp_data %h, required no response", bus.resp_data);
            end else begin
                e = exp_q.pop_front();
                check({e.tag, " data"}, bus.resp_data, e.data);
                if (e.lat != 0) check({e.tag, " latency"}, 32'(vld_rise - e.acc_cyc), 32'(e.lat));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat,
                         input bit expect_resp);
        exp_t e;
        int   t;
        bus.req_valid  = 1'b1;
        bus.req_funct3 = f;
        bus.req_a      = a;
        bus.req_b      = b;
        t = 0;
        while (bus.req_ready !== 1'b1 && t < 100) begin
            tick();
            t++;
        end
        if (t >= 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s accept_timeout: req_ready=%b, required 1", tag, bus.req_ready);
        end
        tick();
        if (expect_resp) begin
            e.tag = tag; e.data = exp; e.lat = lat; e.acc_cyc = cyc;
            exp_q.push_back(e);
        end
        // Operands change after the accept edge; the result must not notice.
        bus.req_valid  = 1'b0;
        bus.req_a      = $urandom;
        bus.req_b      = $urandom;
        bus.req_funct3 = 3'($urandom);
    endtask

    task automatic wait_resp(input string tag);
        int start;
        int t;
        bit busy_ok;
        start = n_resp;
        t = 0;
        busy_ok = 1'b1;
        while (n_resp == start && t < 200) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            tick();
            t++;
        end
        if (t >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s resp_timeout: no response after %0d cycles, required one", tag, t);
        end
        check({tag, " busy"}, 32'(busy_ok), 32'd1);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[16];
        vecs[0]  = '{MD_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 34};
        vecs[1]  = '{MD_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34};
        vecs[2]  = '{MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34};
        vecs[3]  = '{MD_MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 34};
        vecs[4]  = '{MD_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 34};
        vecs[5]  = '{MD_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 34};
        vecs[6]  = '{MD_DIVU,   32'd100,      32'd7,        32'd14,       34};
        vecs[7]  = '{MD_REMU,   32'd100,      32'd7,        32'd2,        34};
        vecs[8]  = '{MD_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34};
        vecs[9]  = '{MD_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 34};
        vecs[10] = '{MD_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 2};
        vecs[11] = '{MD_REM,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 2};
        vecs[12] = '{MD_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34};
        vecs[13] = '{MD_MULHSU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34};
        vecs[14] = '{MD_DIV,    32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 34};
        vecs[15] = '{MD_REM,    32'h00000007, 32'hFFFFFFFE, 32'h00000001, 34};

        rst_n          = 1'b0;
        bus.kill       = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_a      = 32'd0;
        bus.req_b      = 32'd0;
        bus.resp_ready = 1'b1;
        repeat (3) tick();
        check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst req_ready", 32'(bus.req_ready), 32'd0);
        check("rst resp_data", bus.resp_data, 32'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst req_ready", 32'(bus.req_ready), 32'd1);
        tick();

        for (int i = 0; i < 16; i++) begin
            issue($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 1'b1);
            wait_resp($sformatf("vec%0d", i));
        end

        for (int i = 0; i < 8; i++) begin
            logic [31:0] ra, rb, re;
            logic [63:0] p;
            logic [2:0]  f;
            ra = $urandom;
            rb = (i >= 4) ? 32'($urandom_range(1, 1000)) : ($urandom | 32'd1);
            p  = {32'd0, ra} * {32'd0, rb};
            case (i % 4)
                0:       begin f = MD_MUL;   re = p[31:0];  end
                1:       begin f = MD_MULHU; re = p[63:32]; end
                2:       begin f = MD_DIVU;  re = ra / rb;  end
                default: begin f = MD_REMU;  re = ra % rb;  end
            endcase
            issue($sformatf("rnd%0d", i), f, ra, rb, re, 34, 1'b1);
            wait_resp($sformatf("rnd%0d", i));
        end

        // Kill at ITER counter=10, then a clean MUL.
        issue("kill_op", MD_MUL, 32'd5, 32'd5, 32'd25, 0, 1'b0);
        repeat (11) tick();
        check("kill pre busy", 32'(bus.busy), 32'd1);
        bus.kill = 1'b1;
        tick();
        bus.kill = 1'b0;
        check("kill busy", 32'(bus.busy), 32'd0);
        check("kill req_ready", 32'(bus.req_ready), 32'd1);
        check("kill resp_valid", 32'(bus.resp_valid), 32'd0);
        repeat (40) tick();
        issue("after_kill", MD_MUL, 32'd3, 32'd4, 32'd12, 34, 1'b1);
        wait_resp("after_kill");

        // kill outranks a request in IDLE.
        bus.req_valid = 1'b1;
        bus.kill      = 1'b1;
        tick();
        check("kill_idle busy", 32'(bus.busy), 32'd0);
        bus.req_valid = 1'b0;
        bus.kill      = 1'b0;
        tick();
        check("kill_idle busy2", 32'(bus.busy), 32'd0);

        // Backpressure in DONE.
        bus.resp_ready = 1'b0;
        issue("bp", MD_DIVU, 32'd100, 32'd7, 32'd14, 34, 1'b1);
        for (int t = 0; t < 100 && bus.resp_valid !== 1'b1; t++) tick();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp data c%0d", k), bus.resp_data, 32'd14);
            check($sformatf("bp req_ready c%0d", k), 32'(bus.req_ready), 32'd0);
            check($sformatf("bp resp_valid c%0d", k), 32'(bus.resp_valid), 32'd1);
            tick();
        end
        bus.resp_ready = 1'b1;
        wait_resp("bp");

        // Reset mid-ITER: no response, reset values everywhere.
        issue("rst_op", MD_MUL, 32'h1234, 32'h5678, 32'd0, 0, 1'b0);
        repeat (8) tick();
        rst_n = 1'b0;
        tick();
        check("midrst resp_valid", 32'(bus.resp_valid), 32'd0);
        check("midrst busy", 32'(bus.busy), 32'd0);
        check("midrst req_ready", 32'(bus.req_ready), 32'd0);
        check("midrst resp_data", bus.resp_data, 32'd0);
        rst_n = 1'b1;
        repeat (40) tick();
        issue("after_rst", MD_DIV, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 34, 1'b1);
        wait_resp("after_rst");

        check("scoreboard empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
